// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// ----------------
// Command-driven sequencer for an external 4-bit counter whose outputs come
// back to us as q0..q3. Commands arrive over a valid/ready handshake:
//   LOAD      preset the counter to cmd_data
//   RUN_UP    count up until q equals cmd_data
//   RUN_DOWN  count down until q equals cmd_data
//   NOP       accepted and ignored
// While a RUN is active the block watches q, stops the counter on the target
// value, counts wrap-arounds, and reports completion (done) or an early stop
// (aborted).
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   cmd_valid_i  command present
//   cmd_ready_o  command can be accepted (IDLE and not in reset)
//   cmd_op_i     00 LOAD, 01 RUN_UP, 10 RUN_DOWN, 11 NOP
//   cmd_data_i   LOAD value or RUN target
//   stop_i       abort an active RUN (ignored in other states)
//   q0_i..q3_i   counter outputs, q0 is the LSB
//   cnt_en_o     counter steps at the next edge
//   cnt_load_o   counter loads cnt_din_o at the next edge
//   cnt_dir_o    1 = up, 0 = down
//   cnt_din_o    load value
//   done_o       one-cycle pulse, RUN reached its target
//   aborted_o    one-cycle pulse, RUN ended by stop_i
//   wraps_o      saturating wrap-around count for the last/current RUN
//
// The counter is wired through four discrete q inputs, so WIDTH must stay 4.

module counter_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [WIDTH-1:0]  cmd_data_i,
    input  logic              stop_i,
    input  logic              q0_i,
    input  logic              q1_i,
    input  logic              q2_i,
    input  logic              q3_i,
    output logic              cnt_en_o,
    output logic              cnt_load_o,
    output logic              cnt_dir_o,
    output logic [WIDTH-1:0]  cnt_din_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [WRAP_W-1:0] wraps_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_RUN_UP   = 2'b01;
    localparam logic [1:0] OP_RUN_DOWN = 2'b10;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                dir_q, dir_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                aborted_q, aborted_d;

    logic [WIDTH-1:0]    q_w;
    logic                accept_w;
    logic                at_target_w;
    logic                wrap_hit_w;

    // Reassemble the counter value from its individual output bits, LSB first.
    assign q_w = {q3_i, q2_i, q1_i, q0_i};

    // Ready is purely a function of being idle; reset masks it so nothing is
    // accepted on the same edge that the controller is being cleared.
    assign cmd_ready_o = (state_q == ST_IDLE) & ~rst_i;
    assign accept_w    = cmd_valid_i & cmd_ready_o;

    // The single data register is both the RUN target and the LOAD value;
    // every accepted command overwrites it.
    assign at_target_w = (q_w == data_q);

    // A step out of all-ones going up, or out of zero going down, rolls the
    // counter over. The target may legitimately lie behind the start value,
    // so wraps are only counted, never prevented.
    assign wrap_hit_w = dir_q ? (q_w == {WIDTH{1'b1}}) : (q_w == {WIDTH{1'b0}});

    assign cnt_dir_o = dir_q;
    assign cnt_din_o = data_q;
    assign wraps_o   = wraps_q;
    assign aborted_o = aborted_q;

    // Next-state and output decode. The enable in RUN is combinational from
    // q and stop so the counter freezes on the very cycle it reaches the
    // target or is told to stop. Reaching the target takes priority over a
    // simultaneous stop, so that case completes normally without an abort.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        dir_d      = dir_q;
        wraps_d    = wraps_q;
        aborted_d  = 1'b0;
        cnt_en_o   = 1'b0;
        cnt_load_o = 1'b0;
        done_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    data_d = cmd_data_i;
                    case (cmd_op_i)
                        OP_LOAD: begin
                            state_d = ST_LOAD;
                        end
                        OP_RUN_UP: begin
                            state_d = ST_RUN;
                            dir_d   = 1'b1;
                            wraps_d = '0;
                        end
                        OP_RUN_DOWN: begin
                            state_d = ST_RUN;
                            dir_d   = 1'b0;
                            wraps_d = '0;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                cnt_load_o = 1'b1;
                state_d    = ST_IDLE;
            end

            ST_RUN: begin
                cnt_en_o = ~at_target_w & ~stop_i;
                if (at_target_w) begin
                    state_d = ST_DONE;
                end else if (stop_i) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end
                if (cnt_en_o && wrap_hit_w && (wraps_q != {WRAP_W{1'b1}})) begin
                    wraps_d = wraps_q + {{(WRAP_W-1){1'b0}}, 1'b1};
                end
            end

            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any RUN in progress on the
    // same edge and clears the pending abort flag, so a reset never produces
    // a done or aborted pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            dir_q     <= 1'b0;
            wraps_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            dir_q     <= dir_d;
            wraps_q   <= wraps_d;
            aborted_q <= aborted_d;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl
// -------------------
// Directed bench for counter_seq_ctrl. A behavioural 4-bit up/down counter
// closes the loop around the controller: it loads cnt_din on cnt_load, steps
// on cnt_en, and feeds its value back on q0..q3. Each scenario issues a
// command and compares enable/done/aborted per cycle, plus the final counter
// value and wrap count, against hand-worked expectations.

module tb_counter_seq_ctrl;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_RUN_UP   = 2'b01;
    localparam logic [1:0] OP_RUN_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP      = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmdValid = 1'b0;
    logic       cmdReady;
    logic [1:0] cmdOp = OP_NOP;
    logic [3:0] cmdData = 4'h0;
    logic       stopIn = 1'b0;
    logic       cntEn;
    logic       cntLoad;
    logic       cntDir;
    logic [3:0] cntDin;
    logic       done;
    logic       aborted;
    logic [7:0] wraps;
    logic [3:0] cntModel = 4'h0;

    int checks = 0;
    int failures = 0;

    counter_seq_ctrl #(
        .WIDTH (4),
        .WRAP_W(8)
    ) dut (
        .clk_i      (clock),
        .rst_i      (reset),
        .cmd_valid_i(cmdValid),
        .cmd_ready_o(cmdReady),
        .cmd_op_i   (cmdOp),
        .cmd_data_i (cmdData),
        .stop_i     (stopIn),
        .q0_i       (cntModel[0]),
        .q1_i       (cntModel[1]),
        .q2_i       (cntModel[2]),
        .q3_i       (cntModel[3]),
        .cnt_en_o   (cntEn),
        .cnt_load_o (cntLoad),
        .cnt_dir_o  (cntDir),
        .cnt_din_o  (cntDin),
        .done_o     (done),
        .aborted_o  (aborted),
        .wraps_o    (wraps)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    // The external counter being sequenced; it is not tied to the
    // controller's reset, just like the real part.
    always @(posedge clock) begin
        if (cntLoad) begin
            cntModel <= cntDin;
        end else if (cntEn) begin
            cntModel <= cntDir ? cntModel + 4'h1 : cntModel - 4'h1;
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] op,
                                 input logic [3:0] data, input logic stopVal);
        cmdValid = valid;
        cmdOp    = op;
        cmdData  = data;
        stopIn   = stopVal;
        #1;
    endtask

    // Issue a LOAD and confirm the one-cycle load pulse and resulting q.
    task automatic doLoad(input string tag, input logic [3:0] value);
        applyStimulus(1'b1, OP_LOAD, value, 1'b0);
        checkOutput({tag, "_ready"}, 32'(cmdReady), 32'd1);
        nextCycle();
        applyStimulus(1'b0, OP_NOP, 4'h0, 1'b0);
        checkOutput({tag, "_load"}, 32'(cntLoad), 32'd1);
        checkOutput({tag, "_en"}, 32'(cntEn), 32'd0);
        checkOutput({tag, "_din"}, 32'(cntDin), 32'(value));
        nextCycle();
        checkOutput({tag, "_loadoff"}, 32'(cntLoad), 32'd0);
        checkOutput({tag, "_q"}, 32'(cntModel), 32'(value));
    endtask

    // Issue a RUN and walk it cycle by cycle. Cycle numbers count from the
    // accept edge; enCycles is how many leading cycles have cnt_en high, a
    // zero doneCycle/abortCycle means that pulse must never appear, and
    // stopCycle (zero for none) is the single cycle in which stop is driven.
    task automatic runCheck(input string tag, input logic [1:0] op,
                            input logic [3:0] target, input int enCycles,
                            input int doneCycle, input int abortCycle,
                            input int stopCycle, input int expWraps,
                            input logic [3:0] expQ);
        int lastCycle;
        lastCycle = ((doneCycle > abortCycle) ? doneCycle : abortCycle) + 1;
        applyStimulus(1'b1, op, target, 1'b0);
        checkOutput({tag, "_ready"}, 32'(cmdReady), 32'd1);
        nextCycle();
        for (int c = 1; c <= lastCycle; c++) begin
            applyStimulus(1'b0, OP_NOP, 4'h0, c == stopCycle);
            checkOutput($sformatf("%s_en_c%0d", tag, c), 32'(cntEn), 32'(c <= enCycles));
            checkOutput($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(c == doneCycle));
            checkOutput($sformatf("%s_abort_c%0d", tag, c), 32'(aborted), 32'(c == abortCycle));
            checkOutput($sformatf("%s_load_c%0d", tag, c), 32'(cntLoad), 32'd0);
            if (c < lastCycle) begin
                nextCycle();
            end
        end
        checkOutput({tag, "_readyback"}, 32'(cmdReady), 32'd1);
        checkOutput({tag, "_dir"}, 32'(cntDir), 32'(op == OP_RUN_UP));
        checkOutput({tag, "_wraps"}, 32'(wraps), 32'(expWraps));
        checkOutput({tag, "_q"}, 32'(cntModel), 32'(expQ));
        nextCycle();
    endtask

    initial begin
        // Reset held for two cycles: every output quiet, ready masked.
        reset = 1'b1;
        applyStimulus(1'b0, OP_NOP, 4'h0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("rst_ready", 32'(cmdReady), 32'd0);
        checkOutput("rst_en", 32'(cntEn), 32'd0);
        checkOutput("rst_load", 32'(cntLoad), 32'd0);
        checkOutput("rst_dir", 32'(cntDir), 32'd0);
        checkOutput("rst_din", 32'(cntDin), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_abort", 32'(aborted), 32'd0);
        checkOutput("rst_wraps", 32'(wraps), 32'd0);
        reset = 1'b0;
        nextCycle();
        checkOutput("rel_ready", 32'(cmdReady), 32'd1);

        // NOP is accepted and leaves the controller idle.
        applyStimulus(1'b1, OP_NOP, 4'h7, 1'b0);
        nextCycle();
        applyStimulus(1'b0, OP_NOP, 4'h0, 1'b0);
        checkOutput("nop_ready", 32'(cmdReady), 32'd1);
        checkOutput("nop_load", 32'(cntLoad), 32'd0);
        checkOutput("nop_en", 32'(cntEn), 32'd0);

        // LOAD 2 then count up to 5: three steps, done five cycles after accept.
        doLoad("ld2", 4'h2);
        runCheck("up5", OP_RUN_UP, 4'h5, 3, 5, 0, 0, 0, 4'h5);

        // E up to 1 passes through F->0, one wrap.
        doLoad("ldE", 4'hE);
        runCheck("upwrap", OP_RUN_UP, 4'h1, 3, 5, 0, 0, 1, 4'h1);

        // Target already reached: no steps, done two cycles after accept.
        doLoad("ld3", 4'h3);
        runCheck("zero", OP_RUN_DOWN, 4'h3, 0, 2, 0, 0, 0, 4'h3);

        // 1 down to F passes through 0->F, one wrap.
        doLoad("ld1", 4'h1);
        runCheck("dnwrap", OP_RUN_DOWN, 4'hF, 2, 4, 0, 0, 1, 4'hF);

        // Stop in the fourth RUN cycle: q frozen at 3, aborted next cycle.
        doLoad("ld0a", 4'h0);
        runCheck("stop", OP_RUN_UP, 4'h9, 3, 0, 5, 4, 0, 4'h3);

        // Stop on the same cycle the target is reached: done wins.
        doLoad("ld0b", 4'h0);
        runCheck("stoptgt", OP_RUN_UP, 4'h2, 2, 4, 0, 3, 0, 4'h2);

        // Reset in the middle of a RUN, with a command offered meanwhile.
        doLoad("ld0c", 4'h0);
        applyStimulus(1'b1, OP_RUN_UP, 4'h9, 1'b0);
        nextCycle();
        applyStimulus(1'b0, OP_NOP, 4'h0, 1'b0);
        checkOutput("mid_en_c1", 32'(cntEn), 32'd1);
        nextCycle();
        applyStimulus(1'b1, OP_LOAD, 4'hA, 1'b0);
        checkOutput("mid_busy_ready", 32'(cmdReady), 32'd0);
        nextCycle();
        applyStimulus(1'b0, OP_NOP, 4'h0, 1'b0);
        checkOutput("mid_noload", 32'(cntLoad), 32'd0);
        checkOutput("mid_q_c3", 32'(cntModel), 32'd2);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("mid_ready", 32'(cmdReady), 32'd1);
        checkOutput("mid_en", 32'(cntEn), 32'd0);
        checkOutput("mid_done", 32'(done), 32'd0);
        checkOutput("mid_abort", 32'(aborted), 32'd0);
        checkOutput("mid_din", 32'(cntDin), 32'd0);
        nextCycle();
        checkOutput("mid_done2", 32'(done), 32'd0);
        checkOutput("mid_abort2", 32'(aborted), 32'd0);
        checkOutput("mid_ready2", 32'(cmdReady), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
